// File: rtl/tanh_arbiter.sv
// Round-robin arbiter sharing one tanh_table pipeline among NUM_REQ requesters; results return one-hot tagged.
// Define TANH_ARB_FIXED_PRI_EN for a fixed-priority grant (lowest index wins, no last_gnt history).
module tanh_table #(
  parameter int N_LEN   = 16,
  parameter int N_LEN_W = 16,
  parameter int LAT     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LEN-1:0]   d,
  output logic [N_LEN_W-1:0] q
);
  // Signed Q5.10 in and out: ROM holds round(tanh(k/8)*1024) for |x| on a 1/8 grid, saturating at |x| >= 3.9375.
  localparam logic [10:0] TANH_ROM [32] = '{
    11'd0,    11'd127,  11'd251,  11'd367,  11'd473,  11'd568,  11'd650,  11'd721,
    11'd780,  11'd829,  11'd869,  11'd901,  11'd927,  11'd948,  11'd964,  11'd977,
    11'd987,  11'd995,  11'd1001, 11'd1006, 11'd1010, 11'd1013, 11'd1016, 11'd1018,
    11'd1019, 11'd1020, 11'd1021, 11'd1022, 11'd1022, 11'd1023, 11'd1023, 11'd1023
  };

  logic signed [N_LEN:0]   d_ext;
  logic [N_LEN:0]          mag;
  logic [N_LEN:0]          rounded;
  logic                    sat;
  logic [4:0]              idx;
  logic [10:0]             lut_val;
  logic [N_LEN_W-1:0]      lut_ext;
  logic [N_LEN_W-1:0]      lkp;
  logic [LAT-1:0][N_LEN_W-1:0] pipe_reg;

  assign d_ext   = {d[N_LEN-1], d};
  assign mag     = d_ext[N_LEN] ? unsigned'(-d_ext) : unsigned'(d_ext);
  assign rounded = mag + (N_LEN+1)'(64);
  assign sat     = |rounded[N_LEN:12];
  assign idx     = rounded[11:7];
  assign lut_val = sat ? 11'd1024 : TANH_ROM[idx];
  assign lut_ext = N_LEN_W'(lut_val);
  assign lkp     = d_ext[N_LEN] ? (~lut_ext + N_LEN_W'(1)) : lut_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_reg <= '0;
    end else begin
      pipe_reg[0] <= lkp;
      for (int i = 1; i < LAT; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign q = pipe_reg[LAT-1];
endmodule

module tanh_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LAT     = 3,
  parameter int N_LEN   = 16,
  parameter int N_LEN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*N_LEN-1:0] req_d,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       res_valid,
  output logic [N_LEN_W-1:0]       res_q,
  output logic                     busy
);
  logic                   gnt_any;
  logic [ID_W-1:0]        gnt_idx;
  logic [N_LEN-1:0]       table_d;
  logic [N_LEN_W-1:0]     table_q;
  logic [LAT-1:0]         tag_v_reg;
  logic [LAT-1:0][ID_W-1:0] tag_id_reg;
  logic [NUM_REQ-1:0]     res_onehot;
  logic [NUM_REQ-1:0]     res_valid_reg;
  logic [N_LEN_W-1:0]     res_q_reg;

`ifdef TANH_ARB_FIXED_PRI_EN
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    // Descending scan so the lowest valid index is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
    if (!rst_n) gnt_any = 1'b0;
  end
`else
  logic [ID_W-1:0] last_gnt;
  int              cand;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    // Scan offsets far-to-near so the candidate nearest last_gnt+1 wins.
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = int'(last_gnt) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(cand);
      end
    end
    if (!rst_n) gnt_any = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_gnt <= ID_W'(NUM_REQ - 1);
    else if (gnt_any) last_gnt <= gnt_idx;
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_dec
      assign req_ready[gi]  = gnt_any && (gnt_idx == ID_W'(gi));
      assign res_onehot[gi] = tag_v_reg[LAT-1] && (tag_id_reg[LAT-1] == ID_W'(gi));
    end
  endgenerate

  assign table_d = gnt_any ? req_d[gnt_idx*N_LEN +: N_LEN] : '0;

  tanh_table #(.N_LEN(N_LEN), .N_LEN_W(N_LEN_W), .LAT(LAT)) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (table_d),
    .q     (table_q)
  );

  // Tag pipeline runs in lockstep with the table so the last stage names the owner of table_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_reg  <= '0;
      tag_id_reg <= '0;
    end else begin
      tag_v_reg[0]  <= gnt_any;
      tag_id_reg[0] <= gnt_any ? gnt_idx : '0;
      for (int i = 1; i < LAT; i++) begin
        tag_v_reg[i]  <= tag_v_reg[i-1];
        tag_id_reg[i] <= tag_id_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_reg <= '0;
      res_q_reg     <= '0;
    end else begin
      res_valid_reg <= res_onehot;
      res_q_reg     <= tag_v_reg[LAT-1] ? table_q : '0;
    end
  end

  assign res_valid = res_valid_reg;
  assign res_q     = res_q_reg;
  assign busy      = gnt_any | (|tag_v_reg);
endmodule

// File: tb/tb_tanh_arbiter.sv
// Scoreboard bench for tanh_arbiter: grant policy model, result queue with latency/ID/value checks.
module tb_tanh_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LAT     = 3;
  localparam int N_LEN   = 16;
  localparam int N_LEN_W = 16;
  localparam int TOL     = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*N_LEN-1:0] req_d;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       res_valid;
  logic [N_LEN_W-1:0]       res_q;
  logic                     busy;

  tanh_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .LAT(LAT), .N_LEN(N_LEN), .N_LEN_W(N_LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_d     (req_d),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_q     (res_q),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int q;
    int due;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_m   = NUM_REQ - 1;
  bit   pend  [NUM_REQ];
  int   pdata [NUM_REQ];
  int   pexp  [NUM_REQ];

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int exp_tanh(input int d);
    real r;
    r = $tanh(real'(d) / 1024.0) * 1024.0;
    return $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
  endfunction

  function automatic int model_grant(input bit [NUM_REQ-1:0] v);
`ifdef TANH_ARB_FIXED_PRI_EN
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
`else
    for (int off = 1; off <= NUM_REQ; off++) begin
      int c;
      c = (last_m + off) % NUM_REQ;
      if (v[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic post(input int i, input int d);
    pend[i]  = 1'b1;
    pdata[i] = d;
    pexp[i]  = exp_tanh(d);
  endtask

  task automatic flush_pend();
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
  endtask

  function automatic int pend_count();
    int n;
    n = 0;
    for (int i = 0; i < NUM_REQ; i++) n += int'(pend[i]);
    return n;
  endfunction

  task automatic check_results();
    int obs_q;
    obs_q = int'($signed(res_q));
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (obs_q - e.q <= TOL && e.q - obs_q <= TOL) obs_q = e.q;
      check_eq("res_valid", int'(res_valid), 1 << e.id);
      check_eq("res_q", obs_q, e.q);
      $display("result cyc=%0d id=%0d q=%0d want=%0d", cyc, e.id, int'($signed(res_q)), e.q);
    end else begin
      check_eq("res_idle_valid", int'(res_valid), 0);
      check_eq("res_idle_q", obs_q, 0);
    end
  endtask

  // One clock: drive held requests, check grant/busy, score acceptance, then check the result port.
  task automatic tick();
    bit [NUM_REQ-1:0] v;
    int g;
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = pend[i];
      req_d[i*N_LEN +: N_LEN] = N_LEN'(pdata[i]);
    end
    req_valid = v;
    #1;
    g = model_grant(v);
    check_eq("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
    check_eq("busy", int'(busy), int'((g >= 0) || (sb.size() > 0)));
    if (g >= 0) begin
      exp_t e;
      e.id  = g;
      e.q   = pexp[g];
      e.due = cyc + 1 + LAT;
      sb.push_back(e);
      $display("grant cyc=%0d id=%0d d=%0d", cyc + 1, g, pdata[g]);
      pend[g] = 1'b0;
      last_m  = g;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_results();
  endtask

  task automatic drain();
    for (int n = 0; n < 4 * LAT + 8 && sb.size() > 0; n++) tick();
    check_eq("drain_empty", sb.size(), 0);
  endtask

  task automatic run_until_accepted();
    for (int n = 0; n < 16 && pend_count() > 0; n++) tick();
    check_eq("accept_timeout", pend_count(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_d     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0; pdata[i] = 0; pexp[i] = 0;
    end
    #1;
    check_eq("rst_ready", int'(req_ready), 0);
    check_eq("rst_res_valid", int'(res_valid), 0);
    check_eq("rst_res_q", int'(res_q), 0);
    check_eq("rst_busy", int'(busy), 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single request from requester 2, d = 0.5.
    post(2, 512);
    tick();
    for (int n = 0; n < LAT + 2; n++) tick();
    check_eq("single_empty", sb.size(), 0);

    // All four continuously valid with distinct data for 8 cycles.
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend[i]) post(i, (int'($urandom_range(0, 80)) - 40) * 128 + (i == 0 ? 0 : 0));
      tick();
    end
    flush_pend();
    drain();

    // Saturation pass-through.
    post(0, 10240);
    post(1, -10240);
    run_until_accepted();
    drain();

    // Fairness: requester 3 served, then 0 and 3 both valid.
    post(3, 768);
    run_until_accepted();
    post(0, -1536);
    post(3, 2048);
    run_until_accepted();
    drain();

    // Random requests with occasional withdrawals.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) post(i, (int'($urandom_range(0, 80)) - 40) * 128);
        else if (pend[i] && $urandom_range(0, 7) == 0) pend[i] = 1'b0;
      end
      tick();
    end
    flush_pend();
    drain();

    // Reset mid-flight one cycle after three grants.
    post(0, 256); post(1, -384); post(2, 1280);
    tick(); tick(); tick();
    tick();
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    check_eq("mid_rst_ready", int'(req_ready), 0);
    check_eq("mid_rst_res_valid", int'(res_valid), 0);
    check_eq("mid_rst_res_q", int'(res_q), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    sb.delete();
    flush_pend();
    last_m = NUM_REQ - 1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < LAT + 3; n++) tick();
    post(1, 1024);
    tick();
    drain();

    // Requesters 0 and 1 continuously valid: alternate (round-robin) or 0 starves 1 (fixed).
    for (int n = 0; n < 8; n++) begin
      if (!pend[0]) post(0, 128 * n);
      if (!pend[1]) post(1, -128 * n);
      tick();
    end
    flush_pend();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
